aes_final_round_capture: RTL and testbench

//   Captures the 128-bit AES state at the final round of the round pipeline and buffers it in a FWFT FIFO.

---
 rtl/aes_pipe_pkg.sv | 30 +++
 rtl/aes_sync_fifo_fwft.sv | 72 +++++++
 rtl/aes_final_round_capture.sv | 85 ++++++++
 tb/tb_aes_final_round_capture.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pipe_pkg.sv
// Shared constants for the AES round pipeline: final-round tags and key-length encodings.
// The 128-bit state is byte-addressed with byte i on bits [8i+7:8i], i = 0..15.
package aes_pipe_pkg;

  localparam int unsigned STATE_BYTES = 16;
  localparam int unsigned STATE_W     = 8 * STATE_BYTES;

  // Rcon value that travels with the state on the last round of each key size
  localparam logic [7:0] LAST_TAG_128_DEFAULT = 8'h36;
  localparam logic [7:0] LAST_TAG_192_DEFAULT = 8'h80;
  localparam logic [7:0] LAST_TAG_256_DEFAULT = 8'h40;

  typedef enum logic [1:0] {
    KEYLEN_128  = 2'b00,
    KEYLEN_192  = 2'b01,
    KEYLEN_256  = 2'b10,
    KEYLEN_RSVD = 2'b11
  } key_len_e;

  // Mirror the byte order: result byte i = source byte 15-i
  function automatic logic [STATE_W-1:0] reverse_bytes(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(STATE_BYTES); i++) begin
      r[8*i +: 8] = s[8*(int'(STATE_BYTES)-1-i) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. Occupancy is tracked by an
// explicit counter; full/empty come from the counter, never from pointer compare.
// The caller only pushes when there is room (or a pop frees a slot on the same
// edge) and only pops when not empty.
module aes_sync_fifo_fwft #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 128
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointers, occupancy and storage contents
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; reset empties the FIFO
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/aes_final_round_capture.sv
// Captures the AES state on the final round (selected by key length and the
// Rcon tag riding with the state) and queues it for a valid/ready consumer.
// Handshake: out_valid/out_data are held stable until out_ready is seen high
// on a rising edge with out_valid high; that edge transfers the head entry.
// A capture arriving while full with no pop is dropped and sets a sticky overflow.
module aes_final_round_capture
  import aes_pipe_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned BYTE_REVERSE = 0,
  parameter logic [7:0]  LAST_TAG_128 = LAST_TAG_128_DEFAULT,
  parameter logic [7:0]  LAST_TAG_192 = LAST_TAG_192_DEFAULT,
  parameter logic [7:0]  LAST_TAG_256 = LAST_TAG_256_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         round_valid,
  input  logic [7:0]                   rcon_in,
  input  logic [1:0]                   key_len,
  input  logic [STATE_W-1:0]           state_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [STATE_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         overflow
);

  logic [7:0]         sel_tag;
  logic               tag_ok;
  logic               fire;
  logic               push;
  logic               pop;
  logic               empty;
  logic [STATE_W-1:0] wdata;
  logic [STATE_W-1:0] rdata;
  logic               overflow_q, overflow_d;

  // Final-round detection, push/pop arbitration and drop reporting
  always_comb begin
    sel_tag = '0;
    tag_ok  = 1'b0;
    case (key_len_e'(key_len))
      KEYLEN_128: begin sel_tag = LAST_TAG_128; tag_ok = 1'b1; end
      KEYLEN_192: begin sel_tag = LAST_TAG_192; tag_ok = 1'b1; end
      KEYLEN_256: begin sel_tag = LAST_TAG_256; tag_ok = 1'b1; end
      default:    begin sel_tag = '0;           tag_ok = 1'b0; end
    endcase
    fire       = round_valid & tag_ok & (rcon_in == sel_tag);
    pop        = out_valid & out_ready;
    push       = fire & (~full | pop);
    overflow_d = overflow_q | (fire & full & ~pop);
    // Stored words are already in output byte order
    wdata      = (BYTE_REVERSE != 0) ? reverse_bytes(state_in) : state_in;
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  aes_sync_fifo_fwft #(
    .DEPTH (DEPTH),
    .WIDTH (STATE_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (wdata),
    .rdata   (rdata),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = ~empty;
  assign out_data  = out_valid ? rdata : '0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_aes_final_round_capture.sv
// Bench for aes_final_round_capture: directed scenarios followed by random
// traffic, two instances (identity and byte-reversed) sharing the same inputs.
module tb_aes_final_round_capture;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clock = 1'b0;
  logic          reset_n;
  logic          round_valid;
  logic [7:0]    rcon_in;
  logic [1:0]    key_len;
  logic [127:0]  state_in;
  logic          out_ready;

  logic          out_valid,  rev_out_valid;
  logic [127:0]  out_data,   rev_out_data;
  logic [CW-1:0] count,      rev_count;
  logic          full,       rev_full;
  logic          overflow,   rev_overflow;

  always #5 clock = ~clock;

  aes_final_round_capture #(.DEPTH(DEPTH), .BYTE_REVERSE(0)) u_dut (
    .clock(clock), .reset_n(reset_n), .round_valid(round_valid), .rcon_in(rcon_in),
    .key_len(key_len), .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .full(full), .overflow(overflow)
  );

  aes_final_round_capture #(.DEPTH(DEPTH), .BYTE_REVERSE(1)) u_rev (
    .clock(clock), .reset_n(reset_n), .round_valid(round_valid), .rcon_in(rcon_in),
    .key_len(key_len), .state_in(state_in), .out_valid(rev_out_valid), .out_ready(out_ready),
    .out_data(rev_out_data), .count(rev_count), .full(rev_full), .overflow(rev_overflow)
  );

  // ---------------- scoreboard state and reference model ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_rev_q[$];
  int           model_cnt = 0;
  bit           model_ovf = 1'b0;

  function automatic logic [127:0] ref_reverse(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic bit ref_final_round(input logic [7:0] tag, input logic [1:0] kl);
    case (kl)
      2'b00:   return tag == 8'h36;
      2'b01:   return tag == 8'h80;
      2'b10:   return tag == 8'h40;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_status();
    check("count",        128'(count),         128'(model_cnt));
    check("full",         128'(full),          128'(model_cnt == DEPTH));
    check("overflow",     128'(overflow),      128'(model_ovf));
    check("out_valid",    128'(out_valid),     128'(model_cnt != 0));
    check("rev_count",    128'(rev_count),     128'(model_cnt));
    check("rev_overflow", 128'(rev_overflow),  128'(model_ovf));
  endtask

  // ---------------- driver tasks ----------------
  // Drive one cycle of inputs, advance the model, then check status after the edge
  task automatic cycle(input bit rv, input logic [7:0] rc, input logic [1:0] kl,
                       input logic [127:0] st, input bit rdy);
    bit do_pop, do_fire;
    round_valid = rv; rcon_in = rc; key_len = kl; state_in = st; out_ready = rdy;
    do_pop  = (model_cnt > 0) && rdy;
    do_fire = rv && ref_final_round(rc, kl);
    if (do_fire && (model_cnt < DEPTH || do_pop)) begin
      exp_q.push_back(st);
      exp_rev_q.push_back(ref_reverse(st));
      model_cnt++;
    end else if (do_fire) begin
      model_ovf = 1'b1;
    end
    if (do_pop) model_cnt--;
    @(posedge clock); #1;
    check_status();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 2'b00, '0, rdy);
  endtask

  task automatic do_reset();
    round_valid = 1'b0; out_ready = 1'b0; reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    exp_q.delete(); exp_rev_q.delete();
    model_cnt = 0; model_ovf = 1'b0;
    check_status();
  endtask

  // ---------------- monitor: head/data checks on the opposite edge ----------------
  bit           prev_stall = 1'b0;
  logic [127:0] prev_data  = '0;

  always @(negedge clock) begin
    if (reset_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid_held", 128'(out_valid), 128'(1));
        check("stall_data_held",  out_data, prev_data);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_valid_with_empty_model", 128'(out_valid), 128'(0));
        end else begin
          check("head_data",     out_data,     exp_q[0]);
          check("rev_head_data", rev_out_data, exp_rev_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_rev_q.pop_front());
          end
        end
      end else begin
        check("idle_data_zero",     out_data,     '0);
        check("rev_idle_data_zero", rev_out_data, '0);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] w;
    logic [7:0]   tag;
    round_valid = 1'b0; rcon_in = '0; key_len = '0; state_in = '0; out_ready = 1'b0;
    reset_n = 1'b0;

    // Reset then idle
    do_reset();
    idle(20, 1'b0);

    // Single AES-128 capture with the reference vector
    cycle(1'b1, 8'h36, 2'b00, 128'h3925841d02dc09fbdc118597196a0b32, 1'b1);
    idle(2, 1'b1);

    // Mode select
    cycle(1'b1, 8'h36, 2'b01, rand128(), 1'b1);
    cycle(1'b1, 8'h80, 2'b01, rand128(), 1'b1);
    cycle(1'b1, 8'h40, 2'b10, rand128(), 1'b1);
    cycle(1'b1, 8'h80, 2'b10, rand128(), 1'b1);
    cycle(1'b0, 8'h36, 2'b00, rand128(), 1'b1);
    for (int i = 0; i < 6; i++) begin
      tag = (i < 3) ? ((i == 0) ? 8'h36 : (i == 1) ? 8'h80 : 8'h40) : 8'($urandom);
      cycle(1'b1, tag, 2'b11, rand128(), 1'b1);
    end
    idle(2, 1'b1);

    // Back-pressure: five fires into a four-deep FIFO, then release
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h36, 2'b00, rand128(), 1'b0);
    check("bp_full",     128'(full),     128'(1));
    check("bp_overflow", 128'(overflow), 128'(1));
    idle(DEPTH + 2, 1'b1);

    // Full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'h80, 2'b01, rand128(), 1'b0);
    cycle(1'b1, 8'h40, 2'b10, rand128(), 1'b1);
    check("pp_count",    128'(count),    128'(DEPTH));
    check("pp_overflow", 128'(overflow), 128'(0));
    idle(DEPTH + 2, 1'b1);

    // Reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h36, 2'b00, rand128(), 1'b0);
    do_reset();
    check("mid_reset_count", 128'(count),     128'(0));
    check("mid_reset_valid", 128'(out_valid), 128'(0));

    // Byte-reversed instance places captured byte 15 at output byte 0
    w = rand128();
    cycle(1'b1, 8'h36, 2'b00, w, 1'b0);
    check("rev_byte0", 128'(rev_out_data[7:0]), 128'(w[127:120]));
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       tag = 8'h36;
        1:       tag = 8'h80;
        2:       tag = 8'h40;
        default: tag = 8'($urandom);
      endcase
      if (i == 200) do_reset();
      cycle($urandom_range(0, 3) != 0, tag, 2'($urandom_range(0, 3)), rand128(),
            $urandom_range(0, 2) != 0);
    end

    // Drain and confirm every expected word came out
    idle(DEPTH + 2, 1'b1);
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
